nrdiv: RTL

Sequential unsigned non-restoring divider: a 2W-bit dividend divided by a W-bit divisor gives a W-bit quotient and a W-bit remainder. It is the inverse-operation companion to the Booth radix-4 multiplier and uses the same protocol:
- a bgn pulse starts an operation;
- operands arrive one byte per cycle on a shared inbus;
- results return one beat per cycle on outbus, qualified by done.

---
 rtl/nrdiv_if.sv | 14 +
 rtl/nrdiv.sv | 121 ++++++++++++
 2 files changed

// File: rtl/nrdiv_if.sv
// Handshake bundle for the non-restoring divider: start pulse, operand beats in,
// result beats out.
interface nrdiv_if #(
  parameter int W = 8
);
  logic         bgn;
  logic [W-1:0] inbus;
  logic         done;
  logic         ovf;
  logic [W-1:0] outbus;

  modport master (output bgn, inbus, input done, ovf, outbus);
  modport slave  (input bgn, inbus, output done, ovf, outbus);
endinterface

// File: rtl/nrdiv.sv
// Sequential unsigned non-restoring divider: 2W-bit dividend / W-bit divisor,
// operands loaded one beat per cycle, remainder then quotient returned on outbus.
module nrdiv #(
  parameter int W = 8
) (
  input  logic   clk,
  input  logic   rst_b,
  nrdiv_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LD_AH = 4'd1;
  localparam logic [3:0] S_LD_QL = 4'd2;
  localparam logic [3:0] S_LD_M  = 4'd3;
  localparam logic [3:0] S_CHK   = 4'd4;
  localparam logic [3:0] S_ITER  = 4'd5;
  localparam logic [3:0] S_FIX   = 4'd6;
  localparam logic [3:0] S_OUT_R = 4'd7;
  localparam logic [3:0] S_OUT_Q = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [W+1:0]  a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [W+1:0]  m_ext;
  logic [W+1:0]  a_shift;
  logic [W+1:0]  a_step;

  // A is a (W+2)-bit two's-complement partial remainder; the old sign picks add vs subtract.
  assign m_ext   = {2'b00, m_q};
  assign a_shift = {a_q[W:0], q_q[W-1]};
  assign a_step  = a_q[W+1] ? (a_shift + m_ext) : (a_shift - m_ext);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE:  if (bus.bgn) state_d = S_LD_AH;
      S_LD_AH: begin
        a_d     = {2'b00, bus.inbus};
        state_d = S_LD_QL;
      end
      S_LD_QL: begin
        q_d     = bus.inbus;
        state_d = S_LD_M;
      end
      S_LD_M: begin
        m_d     = bus.inbus;
        cnt_d   = '0;
        state_d = S_CHK;
      end
      S_CHK: begin
        // A high dividend half >= M means the quotient cannot fit in W bits.
        if ((m_q == '0) || (a_q[W-1:0] >= m_q)) begin
          ovf_d   = 1'b1;
          state_d = S_OUT_R;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        a_d   = a_step;
        q_d   = {q_q[W-2:0], ~a_step[W+1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (a_q[W+1]) a_d = a_q + m_ext;
        state_d = S_OUT_R;
      end
      S_OUT_R: state_d = S_OUT_Q;
      S_OUT_Q: begin
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    bus.done   = 1'b0;
    bus.ovf    = 1'b0;
    bus.outbus = '0;
    if (state_q == S_OUT_R) begin
      bus.done   = 1'b1;
      bus.ovf    = ovf_q;
      bus.outbus = ovf_q ? '1 : a_q[W-1:0];
    end else if (state_q == S_OUT_Q) begin
      bus.done   = 1'b1;
      bus.ovf    = ovf_q;
      bus.outbus = ovf_q ? '1 : q_q;
    end
  end
endmodule
